// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared mode encodings and table widths for the VDP tile renderer
package vdp_pkg;

    typedef enum logic [1:0] {
        MODE_BLANK = 2'd0,
        MODE_TEST  = 2'd1,
        MODE_TILE  = 2'd2,
        MODE_SOLID = 2'd3
    } vdp_mode_e;

    localparam int PIPE_LAT     = 3;
    localparam int NAME_W       = 8;
    localparam int PAT_ADDR_W   = 11;
    localparam int COLOR_ADDR_W = 5;

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/vdp_delay_line.sv
// rtl/vdp_delay_line.sv - fixed-depth register chain for aligning side signals with the pixel pipe
module vdp_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             pxclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/vdp_tile_render.sv
// rtl/vdp_tile_render.sv - three-stage tile/test-pattern pixel renderer with per-frame mode latch
module vdp_tile_render
    import vdp_pkg::*;
#(
    parameter int COL_W   = 11,
    parameter int ROW_W   = 10,
    parameter int H_SHIFT = 2,
    parameter int V_SHIFT = 2,
    parameter int TC_W    = 5,
    parameter int TR_W    = 5,
    parameter int COLOR_W = 3
) (
    input  logic                      pxclk,
    input  logic                      reset_n,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      active_in,
    input  logic [COL_W-1:0]          col_in,
    input  logic [ROW_W-1:0]          row_in,
    input  logic [1:0]                mode_in,
    input  logic [COLOR_W-1:0]        border_color,
    output logic [TR_W+TC_W-1:0]      name_addr,
    input  logic [NAME_W-1:0]         name_data,
    output logic [PAT_ADDR_W-1:0]     pat_addr,
    input  logic [7:0]                pat_data,
    output logic [COLOR_ADDR_W-1:0]   color_addr,
    input  logic [7:0]                color_data,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      active_out,
    output logic [COLOR_W-1:0]        color
);

    localparam int CMP_W = min_int(TC_W, TR_W);

    logic [TC_W-1:0] c_in;
    logic [TR_W-1:0] r_in;
    logic [2:0]      ccc_in;
    logic [2:0]      rrr_in;
    logic            in_plane;

    assign c_in     = col_in[H_SHIFT+3 +: TC_W];
    assign ccc_in   = col_in[H_SHIFT +: 3];
    assign r_in     = row_in[V_SHIFT+3 +: TR_W];
    assign rrr_in   = row_in[V_SHIFT +: 3];
    assign in_plane = ((col_in >> (H_SHIFT + 3 + TC_W)) == '0) &&
                      ((row_in >> (V_SHIFT + 3 + TR_W)) == '0);

    assign name_addr = {r_in, c_in};

    // A vsync rising edge switches the mode for the pixel arriving with it.
    logic      vsync_prev;
    logic      vsync_rise;
    vdp_mode_e mode_reg;
    vdp_mode_e mode_eff;

    assign vsync_rise = vsync_in & ~vsync_prev;
    assign mode_eff   = vsync_rise ? vdp_mode_e'(mode_in) : mode_reg;

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev <= 1'b0;
            mode_reg   <= MODE_TEST;
        end else begin
            vsync_prev <= vsync_in;
            mode_reg   <= mode_eff;
        end
    end

    logic [2:0] sync_d3;
    logic [2:0] ctl_d2;
    vdp_mode_e  s2_mode;
    logic       s2_active;

    vdp_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT)) u_sync_dly (
        .pxclk   (pxclk),
        .reset_n (reset_n),
        .din     ({hsync_in, vsync_in, active_in}),
        .dout    (sync_d3)
    );

    vdp_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT-1)) u_ctl_dly (
        .pxclk   (pxclk),
        .reset_n (reset_n),
        .din     ({mode_eff, active_in}),
        .dout    (ctl_d2)
    );

    assign hsync_out = sync_d3[2];
    assign vsync_out = sync_d3[1];
    assign active_out = sync_d3[0];
    assign s2_mode   = vdp_mode_e'(ctl_d2[2:1]);
    assign s2_active = ctl_d2[0];

    logic [2:0]      s1_ccc, s1_rrr, s2_ccc, s2_rrr;
    logic [TC_W-1:0] s1_c, s2_c;
    logic [TR_W-1:0] s1_r, s2_r;
    logic            s1_in_plane, s2_in_plane;

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            s1_ccc      <= '0;
            s1_rrr      <= '0;
            s1_c        <= '0;
            s1_r        <= '0;
            s1_in_plane <= 1'b0;
            s2_ccc      <= '0;
            s2_rrr      <= '0;
            s2_c        <= '0;
            s2_r        <= '0;
            s2_in_plane <= 1'b0;
        end else begin
            s1_ccc      <= ccc_in;
            s1_rrr      <= rrr_in;
            s1_c        <= c_in;
            s1_r        <= r_in;
            s1_in_plane <= in_plane;
            s2_ccc      <= s1_ccc;
            s2_rrr      <= s1_rrr;
            s2_c        <= s1_c;
            s2_r        <= s1_r;
            s2_in_plane <= s1_in_plane;
        end
    end

    assign pat_addr   = {name_data, s1_rrr};
    assign color_addr = name_data[7:3];

    logic [TC_W+2:0]    c_ext;
    logic [COLOR_W+2:0] test_c;
    logic [COLOR_W+2:0] diag_sum;
    logic [COLOR_W-1:0] fg, bg, tile_px;
    logic               pat_bit;
    logic [COLOR_W-1:0] color_nxt;

    assign c_ext    = {3'b000, s2_c};
    assign test_c   = {{COLOR_W{1'b0}}, c_ext[2:0]};
    assign diag_sum = {{COLOR_W{1'b0}}, s2_ccc} + {{COLOR_W{1'b0}}, s2_rrr};
    assign fg       = color_data[4 +: COLOR_W];
    assign bg       = color_data[0 +: COLOR_W];
    assign pat_bit  = pat_data[3'd7 - s2_ccc];
    assign tile_px  = pat_bit ? fg : bg;

    always_comb begin
        color_nxt = '0;
        if (s2_active) begin
            unique case (s2_mode)
                MODE_BLANK: color_nxt = '0;
                MODE_TEST: begin
                    if (s2_c[CMP_W-1:0] == s2_r[CMP_W-1:0]) begin
                        color_nxt = diag_sum[COLOR_W-1:0];
                    end else begin
                        color_nxt = test_c[COLOR_W-1:0];
                    end
                end
                MODE_TILE:  color_nxt = s2_in_plane ? tile_px : border_color;
                MODE_SOLID: color_nxt = border_color;
            endcase
        end
    end

    always_ff @(posedge pxclk or negedge reset_n) begin
        if (!reset_n) begin
            color <= '0;
        end else begin
            color <= color_nxt;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{color_data, c_ext, test_c, diag_sum, s2_c, s2_r};

endmodule

// File: tb/tb_vdp_tile_render.sv
// tb/tb_vdp_tile_render.sv - scoreboard bench for vdp_tile_render against a pixel-rule reference model
module tb_vdp_tile_render;

    logic        pxclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, active_in = 1'b0;
    logic [10:0] col_in = '0;
    logic [9:0]  row_in = '0;
    logic [1:0]  mode_in = 2'd0;
    logic [2:0]  border_color = 3'd0;
    logic [9:0]  name_addr;
    logic [7:0]  name_data = '0;
    logic [10:0] pat_addr;
    logic [7:0]  pat_data = '0;
    logic [4:0]  color_addr;
    logic [7:0]  color_data = '0;
    logic        hsync_out, vsync_out, active_out;
    logic [2:0]  color;

    vdp_tile_render dut (
        .pxclk        (pxclk),
        .reset_n      (reset_n),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .active_in    (active_in),
        .col_in       (col_in),
        .row_in       (row_in),
        .mode_in      (mode_in),
        .border_color (border_color),
        .name_addr    (name_addr),
        .name_data    (name_data),
        .pat_addr     (pat_addr),
        .pat_data     (pat_data),
        .color_addr   (color_addr),
        .color_data   (color_data),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .active_out   (active_out),
        .color        (color)
    );

    always #5 pxclk = ~pxclk;

    logic [7:0] name_mem [1024];
    logic [7:0] pat_mem  [2048];
    logic [7:0] color_mem[32];

    always @(posedge pxclk) begin
        name_data  <= name_mem[name_addr];
        pat_data   <= pat_mem[pat_addr];
        color_data <= color_mem[color_addr];
    end

    int cyc = 0;
    always @(posedge pxclk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic [5:0] val;
    } exp_t;

    typedef struct {
        int          tag;
        logic [9:0]  na;
        logic [10:0] pa;
        logic [4:0]  ca;
    } adr_t;

    exp_t exp_q[$];
    adr_t na_q[$];
    adr_t pa_q[$];

    int total = 0;
    int bad = 0;
    int model_mode = 1;
    bit model_prev_vs = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    always @(negedge pxclk) begin
        if (na_q.size() != 0 && na_q[0].tag == cyc) begin
            check("name_addr", int'(name_addr), int'(na_q[0].na));
            void'(na_q.pop_front());
        end
        if (pa_q.size() != 0 && pa_q[0].tag + 1 == cyc) begin
            check("pat_addr", int'(pat_addr), int'(pa_q[0].pa));
            check("color_addr", int'(color_addr), int'(pa_q[0].ca));
            void'(pa_q.pop_front());
        end
        if (exp_q.size() != 0 && exp_q[0].tag + 3 == cyc) begin
            check("out{hs,vs,act,color}", int'({hsync_out, vsync_out, active_out, color}),
                  int'(exp_q[0].val));
            void'(exp_q.pop_front());
        end
    end

    // Drives one pixel for one clock and queues what the renderer must produce for it.
    task automatic issue(input bit hs, input bit vs, input bit act,
                         input int col, input int row, input int mode);
        int c, ccc, r, rrr, nm, pat, cd, pix;
        bit plane;
        exp_t e;
        adr_t a;
        hsync_in  = hs;
        vsync_in  = vs;
        active_in = act;
        col_in    = 11'(col);
        row_in    = 10'(row);
        mode_in   = 2'(mode);

        c     = (col / 32) % 32;
        ccc   = (col / 4) % 8;
        r     = (row / 32) % 32;
        rrr   = (row / 4) % 8;
        plane = (col < 1024) && (row < 1024);
        if (vs && !model_prev_vs) model_mode = mode;
        model_prev_vs = vs;

        nm  = int'(name_mem[r * 32 + c]);
        pat = int'(pat_mem[nm * 8 + rrr]);
        cd  = int'(color_mem[nm / 8]);

        if (!act || model_mode == 0) pix = 0;
        else if (model_mode == 1) pix = (c == r) ? (ccc + rrr) % 8 : c % 8;
        else if (model_mode == 2) begin
            if (!plane) pix = int'(border_color);
            else if (((pat >> (7 - ccc)) & 1) == 1) pix = (cd / 16) % 8;
            else pix = cd % 8;
        end else pix = int'(border_color);

        e.tag = cyc;
        e.val = {hs, vs, act, 3'(pix)};
        exp_q.push_back(e);
        a.tag = cyc;
        a.na  = 10'(r * 32 + c);
        a.pa  = 11'(nm * 8 + rrr);
        a.ca  = 5'(nm / 8);
        na_q.push_back(a);
        pa_q.push_back(a);
        @(posedge pxclk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) name_mem[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) pat_mem[i] = 8'($urandom);
        for (int i = 0; i < 32; i++) color_mem[i] = 8'($urandom);
        name_mem[4 * 32 + 3]  = 8'h41;
        pat_mem[8'h41 * 8 + 5] = 8'h80;
        color_mem[8]          = 8'h52;

        // Reset held across a vsync pulse requesting mode 3: no load may happen.
        hsync_in  = 1'b1;
        active_in = 1'b1;
        mode_in   = 2'd3;
        col_in    = 11'h048;
        row_in    = 10'h04C;
        for (int i = 0; i < 5; i++) begin
            vsync_in = (i == 2);
            @(negedge pxclk);
            check("reset outputs", int'({hsync_out, vsync_out, active_out, color}), 0);
        end
        @(posedge pxclk);
        #1;
        vsync_in     = 1'b0;
        border_color = 3'd3;
        reset_n      = 1'b1;

        issue(0, 0, 1, 'h048, 'h10C, 3);
        issue(1, 0, 1, 'h048, 'h04C, 3);
        issue(0, 0, 1, 'h048, 'h04C, 3);
        issue(0, 1, 1, 96, 148, 2);
        issue(0, 1, 1, 100, 148, 2);
        issue(0, 0, 1, 1100, 148, 2);
        issue(0, 0, 1, 1100 + 4, 400, 2);
        issue(0, 1, 1, 'h048, 'h10C, 1);
        issue(0, 0, 1, 'h048, 'h10C, 3);
        issue(0, 0, 1, 'h048, 'h10C, 3);
        issue(0, 1, 1, 'h048, 'h10C, 3);
        issue(0, 1, 1, 'h048, 'h04C, 3);
        issue(0, 0, 0, 'h048, 'h04C, 3);
        for (int m = 0; m < 4; m++) begin
            issue(0, 1, 0, 'h123, 'h0AB, m);
            issue(0, 0, 0, 'h048, 'h04C, m);
        end
        for (int i = 0; i < 3; i++) issue(0, 0, 0, 0, 0, 0);

        for (int b = 0; b < 40; b++) begin
            border_color = 3'($urandom);
            for (int i = 0; i < 16; i++) begin
                int col;
                col = int'($urandom_range(0, 2047));
                if ($urandom_range(0, 1) == 0) col = col % 1024;
                issue(1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                      col, int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)));
            end
            for (int i = 0; i < 3; i++) issue(1'($urandom), 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge pxclk);
        @(negedge pxclk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
